// File: rtl/cnt_pkg.sv
// Shared definitions for the modulo-N up/down counter: mode constants and load clamp.
package cnt_pkg;

    localparam int unsigned CNT_MODE_WRAP = 0;
    localparam int unsigned CNT_MODE_SAT  = 1;

    // Values at or above the modulus load as the top of the range.
    function automatic logic [32:0] cnt_clamp(input logic [32:0] value, input logic [32:0] modulo);
        return (value < modulo) ? value : (modulo - 33'd1);
    endfunction

endpackage

// File: rtl/cnt_step.sv
// Combinational step for the modulo-N counter: next value and terminal-event flag
// for one enabled step in the direction given by up.
module cnt_step
    import cnt_pkg::*;
#(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MODULO   = 256,
    parameter int unsigned     SATURATE = CNT_MODE_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up,
    output logic [WIDTH-1:0] next,
    output logic             term
);

    localparam logic [WIDTH:0] MaxVal = (WIDTH+1)'(MODULO - 64'd1);

    logic [WIDTH:0] cnt_ext;
    logic [WIDTH:0] nxt_ext;

    assign cnt_ext = {1'b0, count};

    always_comb begin
        nxt_ext = cnt_ext;
        term    = 1'b0;
        if (up) begin
            if (cnt_ext == MaxVal) begin
                term    = 1'b1;
                nxt_ext = (SATURATE == CNT_MODE_SAT) ? MaxVal : '0;
            end else begin
                nxt_ext = cnt_ext + 1'b1;
            end
        end else begin
            if (cnt_ext == '0) begin
                term    = 1'b1;
                nxt_ext = (SATURATE == CNT_MODE_SAT) ? '0 : MaxVal;
            end else begin
                nxt_ext = cnt_ext - 1'b1;
            end
        end
    end

    // Result is always below MODULO, so the extra bit is zero here.
    assign next = WIDTH'(nxt_ext);

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with load, enable, wrap/saturate and registered tc pulse.
// Optional sticky boundary flag ovf with clear ovf_clr when CNT_OVF_EN is defined.
module mod_updown_counter
    import cnt_pkg::*;
#(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MODULO   = 256,
    parameter int unsigned     SATURATE = CNT_MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef CNT_OVF_EN
    input  logic             ovf_clr,
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    if (WIDTH < 1 || WIDTH > 32) begin : gen_bad_width
        $error("mod_updown_counter: WIDTH must be 1..32");
    end
    if (MODULO < 2 || MODULO > (64'd1 << WIDTH)) begin : gen_bad_modulo
        $error("mod_updown_counter: MODULO must be 2..2**WIDTH");
    end
    if (SATURATE != CNT_MODE_WRAP && SATURATE != CNT_MODE_SAT) begin : gen_bad_mode
        $error("mod_updown_counter: SATURATE must be 0 or 1");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] step_next;
    logic             step_term;
    logic [WIDTH-1:0] load_clamped;

    cnt_step #(
        .WIDTH    (WIDTH),
        .MODULO   (MODULO),
        .SATURATE (SATURATE)
    ) u_step (
        .count (count_q),
        .up    (up),
        .next  (step_next),
        .term  (step_term)
    );

    assign load_clamped = WIDTH'(cnt_clamp({1'b0, 32'(load_val)}, 33'(MODULO)));

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = load_clamped;
        end else if (en) begin
            count_d = step_next;
            tc_d    = step_term;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

`ifdef CNT_OVF_EN
    logic ovf_q, ovf_d;

    // A new terminal event outranks a clear on the same edge.
    always_comb begin
        ovf_d = ovf_q;
        if (tc_d) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
